// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// pll_lock_supervisor
//
// Sequences a PLL out of reset, waits for a stable lock and only then releases
// the downstream reset. A lost lock while running pulls the downstream reset
// and starts a fresh attempt. Too many failed attempts park the block in FAULT
// until the next rst_n.
//
// Ports
//   clkin      : block clock, also the PLL reference
//   rst_n      : synchronous, active-low reset
//   lock       : PLL lock flag, asynchronous to clkin (2-flop synchronized)
//   pll_reset  : active-high reset to the PLL (RST_PLL and FAULT)
//   sys_rst_n  : active-low downstream reset, released only in RUN
//   ready      : high while in RUN
//   fault      : high while in FAULT
//   retry_cnt  : attempts started since reset, saturating at 15
//   state_o    : current state (RST_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4)
//
// No valid/ready handshake exists here: every output is a registered level.

module pll_lock_supervisor #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRY      = 7
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       lock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Terminal counts; one 16-bit counter covers every phase because the
    // widest parameter range is 1..65535.
    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

    logic        lock_meta;
    logic        lock_s;
    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [3:0]  retry_nxt;
    // Set by rst_n: the first edge after release is the entry edge of the
    // first attempt, where the pulse count starts and retry_cnt becomes 1.
    logic        start_pending;
    logic        start_pending_nxt;
    logic        failed;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        retry_nxt         = retry_cnt;
        start_pending_nxt = start_pending;
        failed            = 1'b0;

        case (state)
            ST_RST_PLL: begin
                if (start_pending) begin
                    start_pending_nxt = 1'b0;
                    cnt_nxt           = 16'd0;
                    retry_nxt         = sat_inc(retry_cnt);
                end else if (cnt == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested before the timeout so a coincident rise wins.
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = 16'd0;
                end else if (cnt == TIMEOUT_LAST) begin
                    failed = 1'b1;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    failed = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_RUN: begin
                // Relock: retry_cnt is cleared and the new attempt counted in
                // the same edge, so it reads 1.
                if (!lock_s) begin
                    state_nxt = ST_RST_PLL;
                    cnt_nxt   = 16'd0;
                    retry_nxt = 4'd1;
                end
            end
            ST_FAULT: begin
                // Held until rst_n; lock is ignored.
            end
            default: begin
                state_nxt         = ST_RST_PLL;
                cnt_nxt           = 16'd0;
                start_pending_nxt = 1'b1;
            end
        endcase

        if (failed) begin
            cnt_nxt = 16'd0;
            if (retry_cnt < RETRY_LIMIT) begin
                state_nxt = ST_RST_PLL;
                retry_nxt = sat_inc(retry_cnt);
            end else begin
                state_nxt = ST_FAULT;
            end
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state and never combinationally follow lock.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            state         <= ST_RST_PLL;
            cnt           <= 16'd0;
            start_pending <= 1'b1;
            retry_cnt     <= 4'd0;
            pll_reset     <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            lock_meta     <= lock;
            lock_s        <= lock_meta;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            start_pending <= start_pending_nxt;
            retry_cnt     <= retry_nxt;
            pll_reset     <= (state_nxt == ST_RST_PLL) || (state_nxt == ST_FAULT);
            sys_rst_n     <= (state_nxt == ST_RUN);
            ready         <= (state_nxt == ST_RUN);
            fault         <= (state_nxt == ST_FAULT);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
// tb_pll_lock_supervisor
//
// Two supervisors share clock, rst_n and lock:
//   dut_a : RST=4, STABLE=8, TIMEOUT=20, MAX_RETRY=3 (nominal, timeout, glitch, relock)
//   dut_b : RST=2, STABLE=1, TIMEOUT=1, MAX_RETRY=2  (single-cycle boundaries)
// A reference model per instance, written in terms of elapsed time since each
// phase began, pushes the expected outputs after every edge; a monitor pops
// and compares on the falling edge.

module tb_pll_lock_supervisor;

    localparam int A_RST = 4, A_STB = 8, A_TMO = 20, A_MR = 3;
    localparam int B_RST = 2, B_STB = 1, B_TMO = 1,  B_MR = 2;

    localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAULT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic lock;

    logic       pll_a, sys_a, rdy_a, flt_a;
    logic [3:0] retry_a;
    logic [2:0] state_a;
    logic       pll_b, sys_b, rdy_b, flt_b;
    logic [3:0] retry_b;
    logic [2:0] state_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [10:0] exp_q_a[$];
    logic [10:0] exp_q_b[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .RST_CYCLES(A_RST), .STABLE_CYCLES(A_STB),
        .TIMEOUT_CYCLES(A_TMO), .MAX_RETRY(A_MR)
    ) dut_a (
        .clkin(clk), .rst_n(rst_n), .lock(lock),
        .pll_reset(pll_a), .sys_rst_n(sys_a), .ready(rdy_a), .fault(flt_a),
        .retry_cnt(retry_a), .state_o(state_a)
    );

    pll_lock_supervisor #(
        .RST_CYCLES(B_RST), .STABLE_CYCLES(B_STB),
        .TIMEOUT_CYCLES(B_TMO), .MAX_RETRY(B_MR)
    ) dut_b (
        .clkin(clk), .rst_n(rst_n), .lock(lock),
        .pll_reset(pll_b), .sys_rst_n(sys_b), .ready(rdy_b), .fault(flt_b),
        .retry_cnt(retry_b), .state_o(state_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int phase;
        int start;    // edge index at which the current phase was entered
        int tries;
        bit pending;  // first edge after reset release opens attempt 1
        bit d1;       // lock seen one edge ago
        bit d2;       // lock seen two edges ago (what the FSM acts on)
    } mdl_t;

    mdl_t ma, mb;

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic void mdl_step(inout mdl_t m, input int rc, input int sc,
                                     input int tc, input int mr,
                                     input logic rstn, input logic lk, input int now);
        bit ls;
        bit failed;
        ls = m.d2;
        if (!rstn) begin
            m.phase = P_RST; m.start = now; m.tries = 0; m.pending = 1'b1;
            m.d1 = 1'b0; m.d2 = 1'b0;
            return;
        end
        m.d2 = m.d1;
        m.d1 = lk;
        failed = 1'b0;
        case (m.phase)
            P_RST: begin
                if (m.pending) begin
                    m.pending = 1'b0; m.start = now; m.tries = sat15(m.tries + 1);
                end else if (now - m.start == rc) begin
                    m.phase = P_WAIT; m.start = now;
                end
            end
            P_WAIT: begin
                if (ls) begin
                    m.phase = P_STABLE; m.start = now;
                end else if (now - m.start == tc) begin
                    failed = 1'b1;
                end
            end
            P_STABLE: begin
                if (!ls) failed = 1'b1;
                else if (now - m.start == sc) begin
                    m.phase = P_RUN; m.start = now;
                end
            end
            P_RUN: begin
                if (!ls) begin
                    m.phase = P_RST; m.start = now; m.tries = 1;
                end
            end
            default: ;
        endcase
        if (failed) begin
            m.start = now;
            if (m.tries < mr) begin
                m.phase = P_RST; m.tries = sat15(m.tries + 1);
            end else begin
                m.phase = P_FAULT;
            end
        end
    endfunction

    function automatic logic [10:0] mdl_out(input mdl_t m);
        logic [10:0] v;
        v[10:8] = 3'(m.phase);
        v[7:4]  = 4'(m.tries);
        v[3]    = (m.phase == P_RST) || (m.phase == P_FAULT);
        v[2]    = (m.phase == P_RUN);
        v[1]    = (m.phase == P_RUN);
        v[0]    = (m.phase == P_FAULT);
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            mdl_step(ma, A_RST, A_STB, A_TMO, A_MR, rst_n, lock, cyc);
            mdl_step(mb, B_RST, B_STB, B_TMO, B_MR, rst_n, lock, cyc);
            exp_q_a.push_back(mdl_out(ma));
            exp_q_b.push_back(mdl_out(mb));
        end
    end

    // ---------------- scoreboard monitor ----------------
    task automatic check_out(input string name, input logic [10:0] got, input logic [10:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got state=%0d retry=%0d pll_reset=%b sys_rst_n=%b ready=%b fault=%b, want state=%0d retry=%0d pll_reset=%b sys_rst_n=%b ready=%b fault=%b",
                     name, cyc, got[10:8], got[7:4], got[3], got[2], got[1], got[0],
                     exp[10:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow cycle %0d: got empty queue, want one entry", cyc);
            end else begin
                check_out("dut_a", {state_a, retry_a, pll_a, sys_a, rdy_a, flt_a}, exp_q_a.pop_front());
                check_out("dut_b", {state_b, retry_b, pll_b, sys_b, rdy_b, flt_b}, exp_q_b.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        tick(n);
        rst_n = 1'b1;
    endtask

    task automatic drop_lock(input int n);
        lock = 1'b0;
        tick(n);
        lock = 1'b1;
    endtask

    // Bounded wait used only to line up directed stimulus.
    task automatic wait_state_a(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (state_a !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (state_a !== s) begin
            bad++;
            $display("FAIL wait_state_a: got state=%0d, want %0d within %0d cycles", state_a, s, budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        rst_n = 1'b0;
        lock  = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // Nominal: lock rises ~10 cycles after the 4-cycle pulse ends.
        tick(1 + A_RST + 10);
        lock = 1'b1;
        wait_state_a(3'd3, 60);
        tick(5);

        // Relock from RUN after a single-cycle drop, then a longer drop.
        drop_lock(1);
        wait_state_a(3'd3, 60);
        tick(3);
        drop_lock(6);
        wait_state_a(3'd3, 60);

        // Single-cycle glitch in STABLE.
        drop_lock(2);
        wait_state_a(3'd2, 60);
        tick(3);
        drop_lock(1);
        tick(30);

        // Timeout: lock held low through every attempt into FAULT.
        lock = 1'b0;
        tick(3 * (A_RST + A_TMO + 4) + 10);
        wait_state_a(3'd4, 40);

        // Reset during FAULT, then a normal sequence.
        pulse_reset(1);
        lock = 1'b1;
        wait_state_a(3'd2, 60);
        tick(2);

        // Reset during STABLE, then a normal sequence.
        pulse_reset(1);
        wait_state_a(3'd3, 60);
        tick(4);

        // Randomized stretch: lock levels, glitches and resets.
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                pulse_reset($urandom_range(1, 3));
            end else if (r < 22) begin
                lock = ~lock;
                tick(1);
                lock = ~lock;
                tick($urandom_range(1, 30));
            end else begin
                lock = ($urandom_range(0, 3) != 0);
                tick($urandom_range(1, 60));
            end
        end

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
